game_sequencer: RTL and testbench

// - Central game controller for the obstacle game.
// - Sequences IDLE/RUN/HIT/OVER play, paces world updates off the VGA frame pulse,
//   and owns jump timing, the 2-digit BCD score and the speed-up level.
// - Sits between the push-button/VGA timing front end and the obstacle renderer
//   and 7-seg score display.

---
 rtl/game_pkg.sv | 25 ++
 rtl/btn_sync_edge.sv | 37 +++
 rtl/game_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_game_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default pacing constants for the obstacle game controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] TICK_DIV_INIT_DEF = 8'd4;
  localparam logic [7:0] TICK_DIV_MIN_DEF  = 8'd1;
  localparam logic [7:0] SPEEDUP_PTS_DEF   = 8'd10;
  localparam logic [7:0] JUMP_FRAMES_DEF   = 8'd24;
  localparam logic [7:0] HIT_FRAMES_DEF    = 8'd30;
  localparam logic [2:0] SPEED_LEVEL_MAX   = 3'd7;

  // Converts a two-digit BCD score to binary so multiples can be tested.
  function automatic logic [7:0] bcd_to_bin(input bcd_t tens, input bcd_t ones);
    return ({4'd0, tens} * 8'd10) + {4'd0, ones};
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus registered falling-edge detect for an active-low button.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic sync1_q, sync2_q, prev_q, press_q;
  logic sync1_d, sync2_d, prev_d, press_d;

  // Shift the raw button through the synchronizer and flag a 1 -> 0 transition.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    press_d = prev_q & ~sync2_q;
  end

  // Flops idle high (button released) so leaving reset never fakes a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Central obstacle-game controller: play FSM, frame-paced world ticks, jump timer,
// BCD score and speed-up level. Every output comes straight from a flop.
module game_sequencer
  import game_pkg::*;
#(
  parameter logic [7:0] TICK_DIV_INIT = TICK_DIV_INIT_DEF,
  parameter logic [7:0] TICK_DIV_MIN  = TICK_DIV_MIN_DEF,
  parameter logic [7:0] SPEEDUP_PTS   = SPEEDUP_PTS_DEF,
  parameter logic [7:0] JUMP_FRAMES   = JUMP_FRAMES_DEF,
  parameter logic [7:0] HIT_FRAMES    = HIT_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       frame_start,
  input  logic       collision,
  output logic [1:0] state,
  output logic       game_tick,
  output logic       jump_active,
  output logic [2:0] speed_level,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic       score_carry,
  output logic       game_over
);

  logic press;

  game_state_t state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  divider_q, divider_d;
  logic [7:0]  jump_cnt_q, jump_cnt_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic [2:0]  speed_level_q, speed_level_d;
  bcd_t        score_tens_q, score_tens_d;
  bcd_t        score_ones_q, score_ones_d;
  logic        game_tick_q, game_tick_d;
  logic        score_carry_q, score_carry_d;
  logic        jump_active_q, jump_active_d;
  logic        game_over_q, game_over_d;

  bcd_t       inc_tens, inc_ones;
  logic       inc_wrap;
  logic [7:0] inc_bin;
  logic       inc_speedup;

  btn_sync_edge u_btn (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_n),
    .press (press)
  );

  // Score plus one in BCD, with wrap and speed-up detection on the new value.
  always_comb begin
    inc_wrap = 1'b0;
    inc_tens = score_tens_q;
    inc_ones = score_ones_q + 4'd1;
    if (score_ones_q == 4'd9) begin
      inc_ones = 4'd0;
      if (score_tens_q == 4'd9) begin
        inc_tens = 4'd0;
        inc_wrap = 1'b1;
      end else begin
        inc_tens = score_tens_q + 4'd1;
      end
    end
    inc_bin     = bcd_to_bin(inc_tens, inc_ones);
    inc_speedup = (inc_bin != 8'd0) && ((inc_bin % SPEEDUP_PTS) == 8'd0);
  end

  // Next-state, counter and output decisions for the play FSM.
  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    divider_d     = divider_q;
    jump_cnt_d    = jump_cnt_q;
    hit_cnt_d     = hit_cnt_q;
    speed_level_d = speed_level_q;
    score_tens_d  = score_tens_q;
    score_ones_d  = score_ones_q;
    jump_active_d = jump_active_q;
    game_tick_d   = 1'b0;
    score_carry_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (press) begin
          state_d       = RUN;
          score_tens_d  = 4'd0;
          score_ones_d  = 4'd0;
          speed_level_d = 3'd0;
          divider_d     = TICK_DIV_INIT;
          frame_cnt_d   = 8'd0;
          jump_active_d = 1'b0;
          jump_cnt_d    = 8'd0;
        end
      end

      RUN: begin
        if (collision) begin
          // A crash wins over a tick landing in the same cycle.
          state_d       = HIT;
          jump_active_d = 1'b0;
          jump_cnt_d    = 8'd0;
          hit_cnt_d     = 8'd0;
        end else begin
          if (frame_start) begin
            if (frame_cnt_q >= (divider_q - 8'd1)) begin
              frame_cnt_d   = 8'd0;
              game_tick_d   = 1'b1;
              score_carry_d = inc_wrap;
              score_tens_d  = inc_tens;
              score_ones_d  = inc_ones;
              if (inc_speedup) begin
                if (divider_q > TICK_DIV_MIN) begin
                  divider_d = divider_q - 8'd1;
                end
                if (speed_level_q != SPEED_LEVEL_MAX) begin
                  speed_level_d = speed_level_q + 3'd1;
                end
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end

          if (jump_active_q) begin
            if (frame_start) begin
              if (jump_cnt_q <= 8'd1) begin
                jump_cnt_d    = 8'd0;
                jump_active_d = 1'b0;
              end else begin
                jump_cnt_d = jump_cnt_q - 8'd1;
              end
            end
          end else if (press) begin
            jump_active_d = 1'b1;
            jump_cnt_d    = JUMP_FRAMES;
          end
        end
      end

      HIT: begin
        if (frame_start) begin
          if (hit_cnt_q >= (HIT_FRAMES - 8'd1)) begin
            state_d   = OVER;
            hit_cnt_d = 8'd0;
          end else begin
            hit_cnt_d = hit_cnt_q + 8'd1;
          end
        end
      end

      OVER: begin
        if (press) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    game_over_d = (state_d == OVER);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      frame_cnt_q   <= 8'd0;
      divider_q     <= TICK_DIV_INIT;
      jump_cnt_q    <= 8'd0;
      hit_cnt_q     <= 8'd0;
      speed_level_q <= 3'd0;
      score_tens_q  <= 4'd0;
      score_ones_q  <= 4'd0;
      game_tick_q   <= 1'b0;
      score_carry_q <= 1'b0;
      jump_active_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      divider_q     <= divider_d;
      jump_cnt_q    <= jump_cnt_d;
      hit_cnt_q     <= hit_cnt_d;
      speed_level_q <= speed_level_d;
      score_tens_q  <= score_tens_d;
      score_ones_q  <= score_ones_d;
      game_tick_q   <= game_tick_d;
      score_carry_q <= score_carry_d;
      jump_active_q <= jump_active_d;
      game_over_q   <= game_over_d;
    end
  end

  assign state       = state_q;
  assign game_tick   = game_tick_q;
  assign jump_active = jump_active_q;
  assign speed_level = speed_level_q;
  assign score_tens  = score_tens_q;
  assign score_ones  = score_ones_q;
  assign score_carry = score_carry_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: scripted vector table, hand-written
// corner sequences, and a randomized run against a cycle-level behavioural model.
module tb_game_sequencer;

  localparam int INIT_DIV = 4;
  localparam int MIN_DIV  = 1;
  localparam int SPEEDUP  = 10;
  localparam int JUMP     = 24;
  localparam int HITF     = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       collision = 1'b0;
  logic [1:0] state;
  logic       game_tick;
  logic       jump_active;
  logic [2:0] speed_level;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic       score_carry;
  logic       game_over;

  int errors = 0;
  int checks = 0;
  int tick_seen = 0;
  int carry_seen = 0;

  game_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .btn_n       (btn_n),
    .frame_start (frame_start),
    .collision   (collision),
    .state       (state),
    .game_tick   (game_tick),
    .jump_active (jump_active),
    .speed_level (speed_level),
    .score_tens  (score_tens),
    .score_ones  (score_ones),
    .score_carry (score_carry),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // Behavioural reference: integer score, speed-up count and frame phase.
  int         m_state, m_score, m_speedups, m_phase, m_jump_left, m_hit_frames;
  bit         m_tick, m_carry, m_valid;
  logic [3:0] hist;
  bit         m_press;
  int         m_div;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_state = 0; m_score = 0; m_speedups = 0; m_phase = 0;
      m_jump_left = 0; m_hit_frames = 0; m_tick = 1'b0; m_carry = 1'b0;
      hist = 4'hF;
    end else if (m_valid) begin
      // btn_n sampled 3 edges ago low and 4 edges ago high is a press now.
      m_press = !hist[2] && hist[3];
      m_div = (INIT_DIV - m_speedups < MIN_DIV) ? MIN_DIV : INIT_DIV - m_speedups;
      m_tick = 1'b0;
      m_carry = 1'b0;
      case (m_state)
        0: if (m_press) begin
          m_state = 1; m_score = 0; m_speedups = 0; m_phase = 0; m_jump_left = 0;
        end
        1: if (collision) begin
          m_state = 2; m_jump_left = 0; m_hit_frames = 0;
        end else begin
          if (frame_start) begin
            m_phase++;
            if (m_phase == m_div) begin
              m_phase = 0;
              m_tick = 1'b1;
              m_score = (m_score + 1) % 100;
              m_carry = (m_score == 0);
              if (m_score != 0 && m_score % SPEEDUP == 0) m_speedups++;
            end
          end
          if (m_jump_left > 0) begin
            if (frame_start) m_jump_left--;
          end else if (m_press) begin
            m_jump_left = JUMP;
          end
        end
        2: if (frame_start) begin
          m_hit_frames++;
          if (m_hit_frames == HITF) m_state = 3;
        end
        default: if (m_press) m_state = 0;
      endcase
      hist = {hist[2:0], btn_n};
    end
  end

  // Every cycle, compare all outputs against the model and count pulses seen.
  logic [16:0] exp_vec, act_vec;
  logic [2:0]  exp_speed;
  always @(negedge clk) begin
    if (game_tick === 1'b1) tick_seen++;
    if (score_carry === 1'b1) carry_seen++;
    if (m_valid) begin
      exp_speed = (m_speedups > 7) ? 3'd7 : 3'(m_speedups);
      exp_vec = {2'(m_state), m_tick, (m_state == 1 && m_jump_left > 0), exp_speed,
                 4'(m_score / 10), 4'(m_score % 10), m_carry, (m_state == 3)};
      act_vec = {state, game_tick, jump_active, speed_level, score_tens, score_ones,
                 score_carry, game_over};
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL model_cycle t=%0t got=%h expected=%h", $time, act_vec, exp_vec);
      end
    end
  end

  typedef enum int {OP_RESET, OP_PRESS, OP_FRAMES, OP_COLLIDE} op_e;
  typedef struct {
    op_e op;
    int  count;
    int  exp_state;
    int  exp_score;
    int  exp_speed;
    int  exp_ticks;
    int  exp_carries;
  } vec_t;

  vec_t vecs[16];

  task automatic applyStimulus(input op_e op, input int count);
    case (op)
      OP_RESET: begin
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
      end
      OP_PRESS: begin
        @(negedge clk); btn_n = 1'b0;
        repeat (5) @(negedge clk);
        btn_n = 1'b1;
        repeat (6) @(negedge clk);
      end
      OP_FRAMES: begin
        repeat (count) begin
          @(negedge clk); frame_start = 1'b1;
          @(negedge clk); frame_start = 1'b0;
          repeat (2) @(negedge clk);
        end
        @(negedge clk);
      end
      default: begin
        @(negedge clk); collision = 1'b1;
        @(negedge clk); collision = 1'b0;
        @(negedge clk);
      end
    endcase
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    int t0, c0, hold;

    vecs[0]  = '{OP_RESET,   0, 0,  0, 0,  0, 0};
    vecs[1]  = '{OP_PRESS,   0, 1,  0, 0,  0, 0};
    vecs[2]  = '{OP_FRAMES,  8, 1,  2, 0,  2, 0};
    vecs[3]  = '{OP_FRAMES, 32, 1, 10, 1,  8, 0};
    vecs[4]  = '{OP_FRAMES, 30, 1, 20, 2, 10, 0};
    vecs[5]  = '{OP_FRAMES, 20, 1, 30, 3, 10, 0};
    vecs[6]  = '{OP_FRAMES, 10, 1, 40, 4, 10, 0};
    vecs[7]  = '{OP_FRAMES, 59, 1, 99, 7, 59, 0};
    vecs[8]  = '{OP_FRAMES,  1, 1,  0, 7,  1, 1};
    vecs[9]  = '{OP_COLLIDE, 0, 2,  0, 7,  0, 0};
    vecs[10] = '{OP_FRAMES, 29, 2,  0, 7,  0, 0};
    vecs[11] = '{OP_FRAMES,  1, 3,  0, 7,  0, 0};
    vecs[12] = '{OP_PRESS,   0, 0,  0, 7,  0, 0};
    vecs[13] = '{OP_PRESS,   0, 1,  0, 0,  0, 0};
    vecs[14] = '{OP_FRAMES,  5, 1,  1, 0,  1, 0};
    vecs[15] = '{OP_RESET,   0, 0,  0, 0,  0, 0};

    $display("[TB] vector table");
    for (int i = 0; i < 16; i++) begin
      t0 = tick_seen;
      c0 = carry_seen;
      applyStimulus(vecs[i].op, vecs[i].count);
      checkOutput($sformatf("v%0d_state", i), int'(state), vecs[i].exp_state);
      checkOutput($sformatf("v%0d_score", i), int'(score_tens) * 10 + int'(score_ones),
                  vecs[i].exp_score);
      checkOutput($sformatf("v%0d_speed", i), int'(speed_level), vecs[i].exp_speed);
      checkOutput($sformatf("v%0d_over", i), int'(game_over), int'(vecs[i].exp_state == 3));
      checkOutput($sformatf("v%0d_ticks", i), tick_seen - t0, vecs[i].exp_ticks);
      checkOutput($sformatf("v%0d_carries", i), carry_seen - c0, vecs[i].exp_carries);
    end

    $display("[TB] jump sequence");
    applyStimulus(OP_PRESS, 0);
    applyStimulus(OP_PRESS, 0);
    checkOutput("jump_start", int'(jump_active), 1);
    applyStimulus(OP_FRAMES, 12);
    checkOutput("jump_mid", int'(jump_active), 1);
    applyStimulus(OP_PRESS, 0);
    checkOutput("jump_repress", int'(jump_active), 1);
    applyStimulus(OP_FRAMES, 11);
    checkOutput("jump_frame23", int'(jump_active), 1);
    applyStimulus(OP_FRAMES, 1);
    checkOutput("jump_frame24", int'(jump_active), 0);
    checkOutput("jump_score", int'(score_tens) * 10 + int'(score_ones), 6);

    $display("[TB] collision on tick-due frame, then reset in HIT");
    applyStimulus(OP_RESET, 0);
    applyStimulus(OP_PRESS, 0);
    applyStimulus(OP_FRAMES, 4);
    applyStimulus(OP_PRESS, 0);
    applyStimulus(OP_FRAMES, 3);
    @(negedge clk); frame_start = 1'b1; collision = 1'b1;
    @(negedge clk); frame_start = 1'b0; collision = 1'b0;
    checkOutput("crash_tick", int'(game_tick), 0);
    checkOutput("crash_state", int'(state), 2);
    checkOutput("crash_jump", int'(jump_active), 0);
    checkOutput("crash_score", int'(score_tens) * 10 + int'(score_ones), 1);
    applyStimulus(OP_FRAMES, 5);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checkOutput("hit_reset_all",
                int'({state, game_tick, jump_active, speed_level, score_tens, score_ones,
                      score_carry, game_over}), 0);

    $display("[TB] randomized run against model");
    applyStimulus(OP_RESET, 0);
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      frame_start = ($urandom_range(3) == 0);
      collision   = ($urandom_range(199) == 0);
      reset       = ($urandom_range(999) == 0);
      if (hold == 0) begin
        btn_n = ~btn_n;
        hold = $urandom_range(12, 1);
      end else begin
        hold--;
      end
    end
    @(negedge clk);
    frame_start = 1'b0;
    collision = 1'b0;
    reset = 1'b0;
    btn_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
